// File: rtl/sum_acc.sv
// sum_acc: accumulates batches of LEN unsigned operands into a
// registered sum with a sticky carry-out flag; valid/ready on both sides.
//
// Parameters:
//   WIDTH     operand and sum width (default 16)
//   LEN       operands per batch, >= 1 (default 4)
// Ports:
//   Clk       clock, rising edge
//   Rst       synchronous active-high reset
//   In_valid  D carries an operand
//   In_ready  operand accepted this cycle if In_valid (IDLE/ACC, not in reset)
//   D         unsigned operand
//   Out_valid Sum/Ovf hold a completed batch (HOLD state)
//   Out_ready downstream takes the result
//   Sum       accumulated batch sum (registered)
//   Ovf       sticky carry-out flag for the batch
// Build option:
//   SUM_ACC_SAT_EN  saturate acc to all-ones on carry-out instead of wrapping

module sum_acc #(
   parameter int WIDTH = 16,
   parameter int LEN   = 4
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_valid,
   output logic             In_ready,
   input  logic [WIDTH-1:0] D,
   output logic             Out_valid,
   input  logic             Out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Ovf
);

   localparam int CW = $clog2(LEN + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_nxt;
   logic [CW-1:0]    cnt;
   logic             ovf_q;
   logic [WIDTH:0]   sum_ext;
   logic             carry;
   logic             accept;
   logic             last;

   assign accept  = In_valid & In_ready;
   assign sum_ext = {1'b0, acc} + {1'b0, D};
   assign carry   = sum_ext[WIDTH];
   // cnt already counts the operands taken so far in this batch
   assign last    = (cnt == CW'(LEN - 1));

`ifdef SUM_ACC_SAT_EN
   // once saturated, acc is all-ones, so any nonzero D carries again
   assign acc_nxt = carry ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
   assign acc_nxt = sum_ext[WIDTH-1:0];
`endif

   // state register
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = (LEN == 1) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (accept && last) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (Out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // outputs; In_ready is forced low during reset so nothing is taken
   always_comb begin
      In_ready  = 1'b0;
      Out_valid = 1'b0;
      unique case (state)
         IDLE:    In_ready  = ~Rst;
         ACC:     In_ready  = ~Rst;
         HOLD:    Out_valid = 1'b1;
         default: In_ready  = 1'b0;
      endcase
   end

   // datapath
   always_ff @(posedge Clk) begin
      if (Rst) begin
         acc   <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            acc   <= D;
            cnt   <= CW'(1);
            ovf_q <= 1'b0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (carry) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   assign Sum = acc;
   assign Ovf = ovf_q;

endmodule
